// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the block-RAM bridge.
// Holds the HTRANS and HSIZE encodings, the OKAY response code and the
// two-state phase type used by the bridge's write phase machine.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;

    localparam logic HRESP_OKAY = 1'b0;

    // PH_WR_DATA means a write's data phase is in progress this cycle.
    typedef enum logic {
        PH_IDLE    = 1'b0,
        PH_WR_DATA = 1'b1
    } phase_e;

endpackage

// File: rtl/ahb_blockram_if_if.sv
// AHB-Lite slave-side signal bundle for the block-RAM bridge.
// master modport: the bus master / interconnect side.
// slave modport : the bridge side.
// Handshake: a transfer is accepted at a rising clock edge when
// HSEL & HREADY & HTRANS is NONSEQ or SEQ; HREADYOUT completes the data phase.
interface ahb_blockram_if_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );

endinterface

// File: rtl/ahb_byte_strobe.sv
// Combinational byte-lane decode for an AHB transfer.
// Ports:
//   hsize    - HSIZE of the address phase
//   haddr_lo - HADDR[1:0] of the address phase
//   strobe   - per-byte lane enables (bit i = byte lane i)
// Sizes wider than a word produce no lanes, so such writes become no-ops.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] haddr_lo,
    output logic [3:0] strobe
);

    always_comb begin
        strobe = 4'b0000;
        case (hsize)
            HSIZE_BYTE: strobe = 4'b0001 << haddr_lo;
            HSIZE_HALF: strobe = haddr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strobe = 4'b1111;
            default:    strobe = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_blockram_if.sv
// AHB-Lite slave bridge to a simple dual-port block RAM (one read port,
// one byte-enabled write port, same clock, one-cycle registered read).
// Ports:
//   HCLK, HRESETn          - clock, asynchronous active-low reset
//   HSEL..HREADY           - AHB-Lite slave inputs (HPROT ignored)
//   HREADYOUT, HRDATA, HRESP - AHB-Lite slave outputs (never waits, always OKAY)
//   BRAM_RDADDR/BRAM_RDATA - RAM read port, addressed in the address phase
//   BRAM_WRADDR/BRAM_WDATA/BRAM_WRITE - RAM write port, used in the write data phase
//   dbg_state              - current phase machine state
// Reads are zero-wait because the read address goes straight to the RAM in
// the address phase. Writes land one cycle later (in the data phase, when
// HWDATA is valid), so a read of the same word issued right behind a write
// would see stale RAM data; that case is fixed with a byte-merge bypass.
module ahb_blockram_if
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,

    output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
    input  logic [31:0]           BRAM_RDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WRITE,

    output phase_e                dbg_state
);

    phase_e                state_q, state_d;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_word;
    logic [3:0]            strobe;
    logic                  hazard_d;

    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [3:0]            wr_strb_q;
    logic                  hazard_q;
    logic [31:0]           byp_data_q;
    logic [3:0]            byp_strb_q;

    // HPROT and the aliased upper address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, HPROT, HADDR[31:ADDR_WIDTH+2]};

    assign accept    = HSEL && HREADY &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign addr_word = HADDR[ADDR_WIDTH+1:2];

    ahb_byte_strobe u_strobe (
        .hsize    (HSIZE),
        .haddr_lo (HADDR[1:0]),
        .strobe   (strobe)
    );

    // Next phase and hazard detection. A read hitting the word being
    // written this cycle must take the written bytes from the bypass,
    // because the RAM read port samples before the write lands.
    always_comb begin
        state_d  = PH_IDLE;
        hazard_d = 1'b0;
        if (accept && HWRITE) begin
            state_d = PH_WR_DATA;
        end
        if (accept && !HWRITE && (state_q == PH_WR_DATA) &&
            (addr_word == wr_addr_q)) begin
            hazard_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= PH_IDLE;
            wr_addr_q  <= '0;
            wr_strb_q  <= 4'b0000;
            hazard_q   <= 1'b0;
            byp_data_q <= '0;
            byp_strb_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            hazard_q <= hazard_d;
            if (accept && HWRITE) begin
                wr_addr_q <= addr_word;
                wr_strb_q <= strobe;
            end
            if (hazard_d) begin
                byp_data_q <= HWDATA;
                byp_strb_q <= wr_strb_q;
            end
        end
    end

    assign BRAM_RDADDR = addr_word;
    assign BRAM_WRADDR = wr_addr_q;
    assign BRAM_WDATA  = HWDATA;
    // state_q is cleared asynchronously, so reset cancels an in-flight write.
    assign BRAM_WRITE  = (state_q == PH_WR_DATA) ? wr_strb_q : 4'b0000;

    always_comb begin
        HRDATA = BRAM_RDATA;
        for (int i = 0; i < 4; i++) begin
            if (hazard_q && byp_strb_q[i]) begin
                HRDATA[8*i +: 8] = byp_data_q[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = HRESP_OKAY;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_blockram_if.sv
// Self-checking bench for ahb_blockram_if: directed scenarios followed by
// randomized pipelined traffic, checked against a word-array memory model.
module tb_ahb_blockram_if;
    import ahb_pkg::*;

    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic HCLK;
    logic HRESETn;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // ---------------- DUT and RAM ----------------
    ahb_blockram_if_if bus ();

    logic [AW-1:0] bram_rdaddr;
    logic [31:0]   bram_rdata;
    logic [AW-1:0] bram_wraddr;
    logic [31:0]   bram_wdata;
    logic [3:0]    bram_write;
    phase_e        dbg_state;

    ahb_blockram_if #(.ADDR_WIDTH(AW)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL        (bus.HSEL),
        .HADDR       (bus.HADDR),
        .HTRANS      (bus.HTRANS),
        .HSIZE       (bus.HSIZE),
        .HPROT       (bus.HPROT),
        .HWRITE      (bus.HWRITE),
        .HWDATA      (bus.HWDATA),
        .HREADY      (bus.HREADY),
        .HREADYOUT   (bus.HREADYOUT),
        .HRDATA      (bus.HRDATA),
        .HRESP       (bus.HRESP),
        .BRAM_RDADDR (bram_rdaddr),
        .BRAM_RDATA  (bram_rdata),
        .BRAM_WRADDR (bram_wraddr),
        .BRAM_WDATA  (bram_wdata),
        .BRAM_WRITE  (bram_write),
        .dbg_state   (dbg_state)
    );

    // Block RAM: registered read (old data on same-cycle write), byte writes,
    // plus a backdoor load port used to preset words.
    logic [31:0]   bram [0:DEPTH-1] = '{default: 32'h0};
    logic          poke_en;
    logic [AW-1:0] poke_idx;
    logic [31:0]   poke_val;

    always @(posedge HCLK) begin
        bram_rdata <= bram[bram_rdaddr];
        for (int i = 0; i < 4; i++) begin
            if (bram_write[i]) bram[bram_wraddr][8*i +: 8] <= bram_wdata[8*i +: 8];
        end
        if (poke_en) bram[poke_idx] <= poke_val;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_mem [0:DEPTH-1] = '{default: 32'h0};
    logic [31:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Data phase bookkeeping for the transfer accepted at the last edge.
    logic        pend_valid = 1'b0;
    logic        pend_write = 1'b0;
    logic [31:0] pend_addr  = '0;
    logic [2:0]  pend_size  = '0;
    logic [31:0] pend_wdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] word_of(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    // Which byte lanes a transfer touches, from size and low address bits.
    function automatic logic [3:0] lanes_of(input logic [2:0] size, input logic [31:0] a);
        logic [3:0] l;
        l = 4'b0000;
        if (size == 3'd0) begin
            l[a[1:0]] = 1'b1;
        end else if (size == 3'd1) begin
            l[{a[1], 1'b0}] = 1'b1;
            l[{a[1], 1'b1}] = 1'b1;
        end else if (size == 3'd2) begin
            l = 4'b1111;
        end
        return l;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [2:0] size, input logic [31:0] d);
        logic [3:0] l;
        l = lanes_of(size, a);
        for (int i = 0; i < 4; i++) begin
            if (l[i]) ref_mem[word_of(a)][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.HSEL   = 1'b0;
        bus.HADDR  = '0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HSIZE  = HSIZE_WORD;
        bus.HPROT  = 4'b0011;
        bus.HWRITE = 1'b0;
        bus.HREADY = 1'b1;
    endtask

    // One bus cycle: present a new address phase while the previously
    // accepted transfer is in its data phase, then check both at negedge.
    task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic ready,
                             input logic write, input logic [31:0] addr,
                             input logic [2:0] size, input logic [31:0] wdata);
        logic acc;
        @(posedge HCLK);
        #1;
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HREADY = ready;
        bus.HWRITE = write;
        bus.HADDR  = addr;
        bus.HSIZE  = size;
        bus.HPROT  = 4'($urandom_range(0, 15));
        bus.HWDATA = (pend_valid && pend_write) ? pend_wdata : $urandom;
        @(negedge HCLK);
        if (pend_valid && pend_write) begin
            check("wr_strobe", 32'(bram_write), 32'(lanes_of(pend_size, pend_addr)));
            check("wr_addr", 32'(bram_wraddr), 32'(word_of(pend_addr)));
            check("wr_data", bram_wdata, pend_wdata);
            ref_write(pend_addr, pend_size, pend_wdata);
        end else begin
            check("idle_strobe", 32'(bram_write), 32'h0);
            if (pend_valid) begin
                if (exp_q.size() == 0) check("rd_queue_empty", 32'h1, 32'h0);
                else check("rd_data", bus.HRDATA, exp_q.pop_front());
            end
        end
        check("rd_addr", 32'(bram_rdaddr), 32'(word_of(addr)));
        check("okay", {30'h0, bus.HREADYOUT, bus.HRESP}, 32'h2);
        acc = sel && ready && trans[1];
        pend_valid = acc;
        pend_write = write;
        pend_addr  = addr;
        pend_size  = size;
        pend_wdata = wdata;
        if (acc && !write) exp_q.push_back(ref_mem[word_of(addr)]);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        bus_cycle(1'b1, HTRANS_NONSEQ, 1'b1, 1'b1, a, s, d);
    endtask

    task automatic rd(input logic [31:0] a);
        bus_cycle(1'b1, HTRANS_NONSEQ, 1'b1, 1'b0, a, HSIZE_WORD, 32'h0);
    endtask

    task automatic idle();
        bus_cycle(1'b0, HTRANS_IDLE, 1'b1, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    endtask

    // Backdoor preset; call only right after an idle cycle.
    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        ref_mem[word_of(a)] = v;
        poke_idx = word_of(a);
        poke_val = v;
        poke_en  = 1'b1;
        @(posedge HCLK);
        #1;
        poke_en  = 1'b0;
    endtask

    // Pull reset during the data phase of the pending transfer.
    task automatic reset_in_data_phase();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        drive_idle();
        bus.HWDATA = 32'hFFFF_FFFF;
        @(negedge HCLK);
        check("rst_strobe", 32'(bram_write), 32'h0);
        check("rst_wraddr", 32'(bram_wraddr), 32'h0);
        check("rst_wdata", bram_wdata, 32'hFFFF_FFFF);
        check("rst_okay", {30'h0, bus.HREADYOUT, bus.HRESP}, 32'h2);
        check("rst_state", 32'(dbg_state), 32'(PH_IDLE));
        pend_valid = 1'b0;
        exp_q.delete();
        @(posedge HCLK);
        #1;
        check("rst_strobe_hold", 32'(bram_write), 32'h0);
        HRESETn = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a;
        logic [1:0]  tr;
        logic        rdy;

        HRESETn    = 1'b0;
        poke_en    = 1'b0;
        poke_idx   = '0;
        poke_val   = '0;
        drive_idle();
        bus.HWDATA = 32'h1234_5678;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("reset_okay", {30'h0, bus.HREADYOUT, bus.HRESP}, 32'h2);
        check("reset_strobe", 32'(bram_write), 32'h0);
        check("reset_wraddr", 32'(bram_wraddr), 32'h0);
        check("reset_wdata", bram_wdata, 32'h1234_5678);
        check("reset_state", 32'(dbg_state), 32'(PH_IDLE));
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Word write, idle, read back.
        wr(32'h0000_0010, HSIZE_WORD, 32'hDEAD_BEEF);
        idle();
        rd(32'h0000_0010);
        idle();

        // Byte write into a preset word.
        poke(32'h0000_0010, 32'h1122_3344);
        wr(32'h0000_0012, HSIZE_BYTE, 32'h00AB_0000);
        idle();
        rd(32'h0000_0010);
        idle();

        // Halfword write followed immediately by a read of the same word.
        poke(32'h0000_0020, 32'h0000_0000);
        wr(32'h0000_0022, HSIZE_HALF, 32'hCAFE_0000);
        rd(32'h0000_0020);
        idle();

        // Write then read of a different word: no merge.
        poke(32'h0000_0034, 32'h5555_5555);
        wr(32'h0000_0030, HSIZE_WORD, 32'hAAAA_AAAA);
        rd(32'h0000_0034);
        idle();

        // Reset during a write data phase must cancel the write.
        poke(32'h0000_0040, 32'h1234_5678);
        wr(32'h0000_0040, HSIZE_WORD, 32'hA5A5_A5A5);
        reset_in_data_phase();
        rd(32'h0000_0040);
        idle();

        // Oversized write: no lanes, OKAY response, memory unchanged.
        poke(32'h0000_0050, 32'h0BAD_F00D);
        wr(32'h0000_0050, 3'd3, 32'hFFFF_FFFF);
        rd(32'h0000_0050);
        idle();

        // Aliased address: upper bits ignored.
        wr(32'hFFFF_0060, HSIZE_WORD, 32'h6060_6060);
        rd(32'h0000_0060);
        idle();

        // Randomized back-to-back traffic over a small word window to
        // provoke read-after-write hits, with aliasing and idle/busy slots.
        for (int n = 0; n < 600; n++) begin
            a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom);
            tr  = 2'($urandom_range(0, 3));
            rdy = pend_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus_cycle($urandom_range(0, 7) != 0, tr, rdy, 1'($urandom_range(0, 1)),
                      a, 3'($urandom_range(0, 4)), $urandom);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
